// File: rtl/huff_pkg.sv
// Shared widths, FSM states and the 12-bit word layout loaded by huff_encoder.
package huff_pkg;

  localparam int CHAR_W  = 8;
  localparam int FREQ_W  = 3;
  localparam int NUM_SYM = 3;
  localparam int IO_W    = 12;
  localparam int IDX_W   = $clog2(NUM_SYM);
  localparam int CNT_W   = $clog2(NUM_SYM + 1);

  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    DONE
  } state_t;

  // 'char' is a keyword, so the symbol field is named sym_char.
  typedef struct packed {
    logic              valid;
    logic [FREQ_W-1:0] freq;
    logic [CHAR_W-1:0] sym_char;
  } huff_io_t;

endpackage

// File: rtl/huff_freq_counter_if.sv
// Input symbol stream: valid/char/last from the source, ready back from the counter.
interface huff_freq_counter_if;
  import huff_pkg::*;

  logic              in_valid;
  logic [CHAR_W-1:0] in_char;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_char, output in_last, input in_ready);
  modport slave  (input in_valid, input in_char, input in_last, output in_ready);

endinterface

// File: rtl/huff_sym_table.sv
// Symbol table: slot registers, occupancy mask, parallel match and an indexed read port.
module huff_sym_table
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] lookup_char,
  input  logic              inc_en,
  input  logic [IDX_W-1:0]  inc_idx,
  input  logic              alloc_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx,
  output logic              hit_sat,
  output logic              full,
  output huff_io_t          rd_word
);

  logic [CHAR_W-1:0] char_reg [NUM_SYM];
  logic [FREQ_W-1:0] freq_reg [NUM_SYM];
  logic [NUM_SYM-1:0] occ_reg;
  logic [NUM_SYM-1:0] match;
  logic [CNT_W-1:0]  count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SYM; gi++) begin : g_slot
      // Only occupied slots can match, which keeps 8'h00 a legal symbol.
      assign match[gi] = occ_reg[gi] && (char_reg[gi] == lookup_char);

      always_ff @(posedge clk) begin
        if (reset) begin
          occ_reg[gi]  <= 1'b0;
          char_reg[gi] <= '0;
          freq_reg[gi] <= '0;
        end else if (alloc_en && (count_reg == CNT_W'(gi))) begin
          occ_reg[gi]  <= 1'b1;
          char_reg[gi] <= lookup_char;
          freq_reg[gi] <= FREQ_W'(1);
        end else if (inc_en && (inc_idx == IDX_W'(gi)) && (freq_reg[gi] != FREQ_MAX)) begin
          freq_reg[gi] <= freq_reg[gi] + FREQ_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (alloc_en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign hit  = |match;
  assign full = (count_reg == CNT_W'(NUM_SYM));

  always_comb begin
    hit_idx = '0;
    hit_sat = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (match[i]) begin
        hit_idx = IDX_W'(i);
        hit_sat = (freq_reg[i] == FREQ_MAX);
      end
      if (rd_idx == IDX_W'(i)) begin
        rd_word = '{valid: 1'b1, freq: freq_reg[i], sym_char: char_reg[i]};
      end
    end
  end

endmodule

// File: rtl/huff_freq_counter.sv
// Collects a byte stream into a symbol/frequency table, then emits one encoder word per slot.
module huff_freq_counter
  import huff_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  huff_freq_counter_if.slave  in_if,
  output logic [IO_W-1:0]     out_word,
  output logic                done,
  output logic                sym_err,
  output logic                freq_sat
);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] emit_cnt_reg, emit_cnt_next;
  logic [IO_W-1:0]  out_word_reg, out_word_next;
  logic             done_reg, done_next;
  logic             in_ready_reg, in_ready_next;
  logic             sym_err_reg, sym_err_next;
  logic             freq_sat_reg, freq_sat_next;

  logic             hit, hit_sat, full, inc_en, alloc_en;
  logic [IDX_W-1:0] hit_idx;
  huff_io_t         rd_word;

  huff_sym_table u_table (
    .clk         (clk),
    .reset       (reset),
    .lookup_char (in_if.in_char),
    .inc_en      (inc_en),
    .inc_idx     (hit_idx),
    .alloc_en    (alloc_en),
    .rd_idx      (emit_cnt_reg),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .hit_sat     (hit_sat),
    .full        (full),
    .rd_word     (rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= COLLECT;
      emit_cnt_reg <= '0;
      out_word_reg <= '0;
      done_reg     <= 1'b0;
      in_ready_reg <= 1'b1;
      sym_err_reg  <= 1'b0;
      freq_sat_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      emit_cnt_reg <= emit_cnt_next;
      out_word_reg <= out_word_next;
      done_reg     <= done_next;
      in_ready_reg <= in_ready_next;
      sym_err_reg  <= sym_err_next;
      freq_sat_reg <= freq_sat_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    emit_cnt_next = emit_cnt_reg;
    out_word_next = '0;
    done_next     = 1'b0;
    in_ready_next = 1'b0;
    sym_err_next  = sym_err_reg;
    freq_sat_next = freq_sat_reg;
    inc_en        = 1'b0;
    alloc_en      = 1'b0;
    unique case (state_reg)
      COLLECT: begin
        in_ready_next = 1'b1;
        if (in_if.in_valid) begin
          if (hit) begin
            inc_en = 1'b1;
            if (hit_sat) freq_sat_next = 1'b1;
          end else if (!full) begin
            alloc_en = 1'b1;
          end else begin
            sym_err_next = 1'b1;
          end
          // A dropped final symbol still ends collection.
          if (in_if.in_last) begin
            state_next    = EMIT;
            in_ready_next = 1'b0;
            emit_cnt_next = '0;
          end
        end
      end
      EMIT: begin
        out_word_next = rd_word;
        emit_cnt_next = emit_cnt_reg + IDX_W'(1);
        if (emit_cnt_reg == IDX_W'(NUM_SYM - 1)) state_next = DONE;
      end
      DONE: begin
        done_next = 1'b1;
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  assign in_if.in_ready = in_ready_reg;
  assign out_word       = out_word_reg;
  assign done           = done_reg;
  assign sym_err        = sym_err_reg;
  assign freq_sat       = freq_sat_reg;

endmodule

// File: tb/tb_huff_freq_counter.sv
// Scoreboard bench: each scenario queues its expected words, streams symbols, then drains the emission.
module tb_huff_freq_counter;
  import huff_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [IO_W-1:0] out_word;
  logic            done, sym_err, freq_sat;
  logic [IO_W-1:0] sb [$];
  logic [IO_W-1:0] exp_word;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  huff_freq_counter_if in_if ();

  huff_freq_counter dut (
    .clk      (clk),
    .reset    (reset),
    .in_if    (in_if),
    .out_word (out_word),
    .done     (done),
    .sym_err  (sym_err),
    .freq_sat (freq_sat)
  );

  task automatic drive(input logic [CHAR_W-1:0] c, input logic v, input logic l);
    @(negedge clk);
    in_if.in_valid = v;
    in_if.in_char  = c;
    in_if.in_last  = l;
    @(posedge clk);
    $display("drive valid=%b char=%h last=%b", v, c, l);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    in_if.in_char  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    in_if.in_char  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_word !== 12'h000 || done !== 1'b0 || in_if.in_ready !== 1'b1 ||
        sym_err !== 1'b0 || freq_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got word=%h done=%b ready=%b err=%b sat=%b want 000 0 1 0 0",
               out_word, done, in_if.in_ready, sym_err, freq_sat);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [CHAR_W-1:0] msg [8];
    msg = '{8'h61, 8'h6E, 8'h61, 8'h6D, 8'h6E, 8'h61, 8'h6D, 8'h6E};
    apply_reset();
    sb.push_back(12'hB61); sb.push_back(12'hB6E); sb.push_back(12'hA6D);
    for (int i = 0; i < 8; i++) drive(msg[i], 1'b1, i == 7);
    @(negedge clk);
    in_if.in_valid = 1'b0; in_if.in_last = 1'b0;
    checks++;
    if (in_if.in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_drop got %b want 0", in_if.in_ready);
    end
    for (int k = 0; k < NUM_SYM; k++) begin
      @(posedge clk); #1;
      exp_word = sb.pop_front();
      checks++;
      if (out_word !== exp_word || done !== 1'b0) begin
        errors++; $display("FAIL basic_slot%0d got %h done=%b want %h done=0", k, out_word, done, exp_word);
      end else $display("basic slot%0d word %h", k, out_word);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || out_word !== 12'h000 || sym_err !== 1'b0 || freq_sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b word=%h err=%b sat=%b want 1 000 0 0", done, out_word, sym_err, freq_sat);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || out_word !== 12'h000 || in_if.in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_hold got done=%b word=%h ready=%b want 1 000 0", done, out_word, in_if.in_ready);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    sb.push_back(12'hF78); sb.push_back(12'h800); sb.push_back(12'h800);
    for (int i = 0; i < 9; i++) drive(8'h78, 1'b1, i == 8);
    @(negedge clk);
    in_if.in_valid = 1'b0; in_if.in_last = 1'b0;
    for (int k = 0; k < NUM_SYM; k++) begin
      @(posedge clk); #1;
      exp_word = sb.pop_front();
      checks++;
      if (out_word !== exp_word) begin
        errors++; $display("FAIL sat_slot%0d got %h want %h", k, out_word, exp_word);
      end else $display("sat slot%0d word %h", k, out_word);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || freq_sat !== 1'b1 || sym_err !== 1'b0) begin
      errors++; $display("FAIL sat_flags got done=%b sat=%b err=%b want 1 1 0", done, freq_sat, sym_err);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    sb.push_back(12'h961); sb.push_back(12'h962); sb.push_back(12'h963);
    drive(8'h61, 1'b1, 1'b0);
    drive(8'h62, 1'b1, 1'b0);
    drive(8'h63, 1'b1, 1'b0);
    drive(8'h64, 1'b1, 1'b1);
    @(negedge clk);
    in_if.in_valid = 1'b0; in_if.in_last = 1'b0;
    for (int k = 0; k < NUM_SYM; k++) begin
      @(posedge clk); #1;
      exp_word = sb.pop_front();
      checks++;
      if (out_word !== exp_word) begin
        errors++; $display("FAIL ovf_slot%0d got %h want %h", k, out_word, exp_word);
      end else $display("ovf slot%0d word %h", k, out_word);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || sym_err !== 1'b1 || freq_sat !== 1'b0) begin
      errors++; $display("FAIL ovf_flags got done=%b err=%b sat=%b want 1 1 0", done, sym_err, freq_sat);
    end
  endtask

  task automatic test_zero_char();
    apply_reset();
    sb.push_back(12'h900); sb.push_back(12'h800); sb.push_back(12'h800);
    drive(8'h00, 1'b1, 1'b1);
    @(negedge clk);
    in_if.in_valid = 1'b0; in_if.in_last = 1'b0;
    for (int k = 0; k < NUM_SYM; k++) begin
      @(posedge clk); #1;
      exp_word = sb.pop_front();
      checks++;
      if (out_word !== exp_word) begin
        errors++; $display("FAIL zero_slot%0d got %h want %h", k, out_word, exp_word);
      end else $display("zero slot%0d word %h", k, out_word);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    sb.push_back(12'hA61); sb.push_back(12'h962); sb.push_back(12'h800);
    drive(8'h61, 1'b1, 1'b0);
    drive(8'h61, 1'b0, 1'b1);
    drive(8'h62, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (in_if.in_ready !== 1'b1 || done !== 1'b0 || out_word !== 12'h000) begin
      errors++; $display("FAIL gap_no_emit got ready=%b done=%b word=%h want 1 0 000", in_if.in_ready, done, out_word);
    end
    drive(8'h62, 1'b1, 1'b0);
    drive(8'h63, 1'b0, 1'b0);
    drive(8'h61, 1'b1, 1'b1);
    @(negedge clk);
    in_if.in_valid = 1'b0; in_if.in_last = 1'b0;
    for (int k = 0; k < NUM_SYM; k++) begin
      @(posedge clk); #1;
      exp_word = sb.pop_front();
      checks++;
      if (out_word !== exp_word) begin
        errors++; $display("FAIL gap_slot%0d got %h want %h", k, out_word, exp_word);
      end else $display("gap slot%0d word %h", k, out_word);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    sb.push_back(12'hB61);
    drive(8'h61, 1'b1, 1'b0);
    drive(8'h61, 1'b1, 1'b0);
    drive(8'h61, 1'b1, 1'b1);
    @(negedge clk);
    in_if.in_valid = 1'b0; in_if.in_last = 1'b0;
    @(posedge clk); #1;
    exp_word = sb.pop_front();
    checks++;
    if (out_word !== exp_word) begin
      errors++; $display("FAIL mid_slot0 got %h want %h", out_word, exp_word);
    end else $display("mid slot0 word %h", out_word);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_word !== 12'h000 || in_if.in_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got word=%h ready=%b done=%b want 000 1 0", out_word, in_if.in_ready, done);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(12'hA61); sb.push_back(12'h800); sb.push_back(12'h800);
    drive(8'h61, 1'b1, 1'b0);
    drive(8'h61, 1'b1, 1'b1);
    @(negedge clk);
    in_if.in_valid = 1'b0; in_if.in_last = 1'b0;
    for (int k = 0; k < NUM_SYM; k++) begin
      @(posedge clk); #1;
      exp_word = sb.pop_front();
      checks++;
      if (out_word !== exp_word) begin
        errors++; $display("FAIL mid_new_slot%0d got %h want %h", k, out_word, exp_word);
      end else $display("mid new slot%0d word %h", k, out_word);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    in_if.in_char  = '0;
    test_reset();
    test_basic();
    test_saturate();
    test_overflow();
    test_zero_char();
    test_gaps();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
